// File: rtl/rx_align_pkg.sv
// Shared types and constants for the 66b block alignment path.
package rx_align_pkg;

  localparam int unsigned GBOX_W  = 194;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned OFF_W   = 7;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned HDR_W   = 2;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BLK_W   = HDR_W + DATA_W;
  localparam int unsigned ERR_W   = 16;
  localparam int unsigned STATE_W = 2;

  // Header bit position of the view window at gbox_cnt=0, offset=0.
  localparam int unsigned IDX_TOP = 193;
  // Lowest header position that still leaves a full 64-bit payload below it.
  localparam int unsigned IDX_MIN = 65;
  // Largest offset the seeker can legitimately report.
  localparam int unsigned OFF_MAX = 66;

  // Descrambler polynomial 1 + x^39 + x^58.
  localparam int unsigned DS_W   = 58;
  localparam int unsigned DS_TAP = 39;

  localparam logic [HDR_W-1:0] c_DATA_HEADER = 2'b01;
  localparam logic [HDR_W-1:0] c_CMD_HEADER  = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  typedef struct packed {
    logic [HDR_W-1:0]  hdr;
    logic [DATA_W-1:0] data;
  } block_t;

  // A sync header is valid only when its two bits differ.
  function automatic logic hdr_is_good(input logic [HDR_W-1:0] hdr);
    return (hdr == c_DATA_HEADER) || (hdr == c_CMD_HEADER);
  endfunction

endpackage

// File: rtl/rx_descrambler58.sv
// Self-synchronising 1+x^39+x^58 descrambler, LSB-first over a 64-bit word.
// The descrambled word is combinational; history advances only when told to.
module rx_descrambler58
  import rx_align_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_c_o
);

  logic [DS_W-1:0] state_q;
  logic [DS_W-1:0] state_d;

  // Descramble bit by bit; history holds the most recent received bits, newest at bit 0.
  always_comb begin
    logic [DS_W-1:0] hist;
    hist     = state_q;
    data_c_o = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      data_c_o[i] = data_i[i] ^ hist[DS_TAP-1] ^ hist[DS_W-1];
      hist        = {hist[DS_W-2:0], data_i[i]};
    end
    state_d = hist;
  end

  // History register: cleared on lock entry, advanced per emitted block.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= '0;
    end else if (clear_i) begin
      state_q <= '0;
    end else if (advance_i) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/block_aligner.sv
// 66b block aligner: hunt/verify/lock on the sync header and extraction of
// aligned blocks from the gearbox buffer.
// Optional build macro BLOCK_ALIGNER_DESCRAMBLE_EN inserts a payload descrambler
// ahead of the output register; undefined, the payload is passed through raw.
module block_aligner
  import rx_align_pkg::*;
#(
  parameter int unsigned N_STABLE = 4,
  parameter int unsigned N_LOCK   = 32,
  parameter int unsigned BAD_WIN  = 64,
  parameter int unsigned BAD_MAX  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [GBOX_W-1:0]   gbox_buffer,
  input  logic [CNT_W-1:0]    gbox_cnt,
  input  logic                buffer_dv,
  input  logic [OFF_W-1:0]    block_offset,
  output logic [HDR_W-1:0]    blk_header_o,
  output logic [DATA_W-1:0]   blk_data_o,
  output logic                blk_valid_o,
  output logic                locked_o,
  output logic [STATE_W-1:0]  lock_state_o,
  output logic [ERR_W-1:0]    hdr_err_cnt_o
);

  localparam int unsigned STABLE_W = $clog2(N_STABLE + 1);
  localparam int unsigned GOOD_W   = $clog2(N_LOCK + 1);
  localparam int unsigned WIN_W    = $clog2(BAD_WIN);
  localparam int unsigned BAD_W    = $clog2(BAD_MAX + 1);

  align_state_t          state_q,      state_d;
  logic [STABLE_W-1:0]   stable_cnt_q, stable_cnt_d;
  logic [OFF_W-1:0]      prev_off_q,   prev_off_d;
  logic [OFF_W-1:0]      locked_off_q, locked_off_d;
  logic [GOOD_W-1:0]     good_cnt_q,   good_cnt_d;
  logic [WIN_W-1:0]      win_cnt_q,    win_cnt_d;
  logic [BAD_W-1:0]      bad_cnt_q,    bad_cnt_d;
  logic [ERR_W-1:0]      err_cnt_q,    err_cnt_d;
  block_t                blk_q,        blk_d;
  logic                  blk_valid_q,  blk_valid_d;
  logic                  locked_q,     locked_d;

  logic [OFF_W-1:0]      act_off;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      shamt;
  logic                  in_range;
  logic [BLK_W-1:0]      window;
  block_t                blk_raw;
  logic                  hdr_good;
  logic [DATA_W-1:0]     emit_data;
  logic                  emit_c;

  logic [STABLE_W-1:0]   stable_inc;
  logic [GOOD_W-1:0]     good_inc;
  logic [BAD_W-1:0]      bad_inc;

  // Locate the 66b block in the buffer; out-of-range positions yield a bad header.
  always_comb begin
    act_off  = (state_q == HUNT) ? block_offset : locked_off_q;
    idx      = IDX_W'(IDX_TOP) - IDX_W'(gbox_cnt) - IDX_W'(act_off);
    in_range = (idx >= IDX_W'(IDX_MIN)) && (act_off <= OFF_W'(OFF_MAX));
    shamt    = in_range ? (idx - IDX_W'(IDX_MIN)) : '0;
    window   = BLK_W'(gbox_buffer >> shamt);
    blk_raw  = window;
    hdr_good = in_range && hdr_is_good(blk_raw.hdr);
  end

`ifdef BLOCK_ALIGNER_DESCRAMBLE_EN
  logic descr_clear_c;

  assign descr_clear_c = (state_q == VERIFY) && (state_d == LOCKED);

  rx_descrambler58 u_descrambler (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (descr_clear_c),
    .advance_i (emit_c),
    .data_i    (blk_raw.data),
    .data_c_o  (emit_data)
  );
`else
  assign emit_data = blk_raw.data;
`endif

  // Hunt/verify/lock next-state, counters and block emission.
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    prev_off_d   = prev_off_q;
    locked_off_d = locked_off_q;
    good_cnt_d   = good_cnt_q;
    win_cnt_d    = win_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    err_cnt_d    = err_cnt_q;
    blk_d        = blk_q;
    blk_valid_d  = 1'b0;
    emit_c       = 1'b0;

    stable_inc = (stable_cnt_q == STABLE_W'(N_STABLE)) ? stable_cnt_q
                                                       : stable_cnt_q + 1'b1;
    good_inc   = good_cnt_q + 1'b1;
    bad_inc    = bad_cnt_q + 1'b1;

    if (buffer_dv) begin
      unique case (state_q)
        HUNT: begin
          prev_off_d   = block_offset;
          stable_cnt_d = (block_offset == prev_off_q) ? stable_inc : STABLE_W'(1);
          if (stable_cnt_d == STABLE_W'(N_STABLE)) begin
            locked_off_d = block_offset;
            good_cnt_d   = '0;
            state_d      = VERIFY;
          end
        end

        VERIFY: begin
          if (hdr_good) begin
            good_cnt_d = good_inc;
            if (good_inc == GOOD_W'(N_LOCK)) begin
              win_cnt_d = '0;
              bad_cnt_d = '0;
              state_d   = LOCKED;
            end
          end else begin
            stable_cnt_d = '0;
            state_d      = HUNT;
          end
        end

        LOCKED: begin
          // Window length is a power of two, so the counter wraps on its own.
          win_cnt_d = win_cnt_q + 1'b1;
          if (hdr_good) begin
            emit_c      = 1'b1;
            blk_valid_d = 1'b1;
            blk_d.hdr   = blk_raw.hdr;
            blk_d.data  = emit_data;
          end else begin
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            bad_cnt_d = bad_inc;
            if (bad_inc == BAD_W'(BAD_MAX)) begin
              stable_cnt_d = '0;
              state_d      = HUNT;
            end
          end
          // Window end clears the bad count after the threshold has been judged.
          if (win_cnt_q == WIN_W'(BAD_WIN - 1)) begin
            bad_cnt_d = '0;
          end
        end

        default: begin
          stable_cnt_d = '0;
          state_d      = HUNT;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= HUNT;
      stable_cnt_q <= '0;
      prev_off_q   <= '0;
      locked_off_q <= '0;
      good_cnt_q   <= '0;
      win_cnt_q    <= '0;
      bad_cnt_q    <= '0;
      err_cnt_q    <= '0;
      blk_q        <= '0;
      blk_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      prev_off_q   <= prev_off_d;
      locked_off_q <= locked_off_d;
      good_cnt_q   <= good_cnt_d;
      win_cnt_q    <= win_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      err_cnt_q    <= err_cnt_d;
      blk_q        <= blk_d;
      blk_valid_q  <= blk_valid_d;
      locked_q     <= locked_d;
    end
  end

  assign blk_header_o  = blk_q.hdr;
  assign blk_data_o    = blk_q.data;
  assign blk_valid_o   = blk_valid_q;
  assign locked_o      = locked_q;
  assign lock_state_o  = state_q;
  assign hdr_err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_block_aligner.sv
// Self-checking bench for block_aligner: directed lock scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_block_aligner;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [193:0] gbox_buffer;
  logic [5:0]   gbox_cnt;
  logic         buffer_dv;
  logic [6:0]   block_offset;
  logic [1:0]   blk_header_o;
  logic [63:0]  blk_data_o;
  logic         blk_valid_o;
  logic         locked_o;
  logic [1:0]   lock_state_o;
  logic [15:0]  hdr_err_cnt_o;

  always #5 clk = ~clk;

  block_aligner dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .gbox_buffer   (gbox_buffer),
    .gbox_cnt      (gbox_cnt),
    .buffer_dv     (buffer_dv),
    .block_offset  (block_offset),
    .blk_header_o  (blk_header_o),
    .blk_data_o    (blk_data_o),
    .blk_valid_o   (blk_valid_o),
    .locked_o      (locked_o),
    .lock_state_o  (lock_state_o),
    .hdr_err_cnt_o (hdr_err_cnt_o)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model state (0=HUNT, 1=VERIFY, 2=LOCKED).
  int          m_state, m_stable, m_prev, m_lock_off, m_good, m_win, m_bad, m_err;
  logic        m_valid;
  logic [1:0]  m_hdr;
  logic [63:0] m_data;
  logic [57:0] m_ds;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_stable = 0; m_prev = 0; m_lock_off = 0; m_good = 0;
    m_win = 0; m_bad = 0; m_err = 0; m_valid = 1'b0; m_hdr = '0; m_data = '0; m_ds = '0;
  endtask

  function automatic logic [63:0] descr(input logic [63:0] d);
`ifdef BLOCK_ALIGNER_DESCRAMBLE_EN
    logic [63:0] o;
    for (int i = 0; i < 64; i++) begin
      o[i] = d[i] ^ m_ds[38] ^ m_ds[57];
      m_ds = {m_ds[56:0], d[i]};
    end
    return o;
`else
    return d;
`endif
  endfunction

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    int off, idx;
    logic inr, good;
    logic [1:0] h;
    logic [63:0] d;
    m_valid = 1'b0;
    if (rst_i) begin model_reset(); return; end
    if (!buffer_dv) return;
    off = (m_state == 0) ? int'(block_offset) : m_lock_off;
    idx = 193 - int'(gbox_cnt) - off;
    inr = (idx >= 65) && (off <= 66);
    h = '0; d = '0;
    if (inr) begin
      h = {gbox_buffer[idx], gbox_buffer[idx-1]};
      for (int j = 0; j < 64; j++) d[63-j] = gbox_buffer[idx-2-j];
    end
    good = inr && (h == 2'b01 || h == 2'b10);
    case (m_state)
      0: begin
        if (int'(block_offset) == m_prev) m_stable = (m_stable < 4) ? m_stable + 1 : 4;
        else m_stable = 1;
        m_prev = int'(block_offset);
        if (m_stable == 4) begin m_lock_off = int'(block_offset); m_state = 1; m_good = 0; end
      end
      1: begin
        if (good) begin
          m_good++;
          if (m_good == 32) begin m_state = 2; m_win = 0; m_bad = 0; m_ds = '0; end
        end else begin
          m_state = 0; m_stable = 0;
        end
      end
      default: begin
        if (good) begin
          m_valid = 1'b1; m_hdr = h; m_data = descr(d);
        end else begin
          m_bad++;
          if (m_err < 65535) m_err++;
        end
        if (m_bad == 16) begin m_state = 0; m_stable = 0; end
        if (m_win == 63) m_bad = 0;
        m_win = (m_win + 1) % 64;
      end
    endcase
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid",  64'(blk_valid_o),   64'(m_valid));
      chk("locked", 64'(locked_o),      64'(m_state == 2));
      chk("state",  64'(lock_state_o),  64'(m_state));
      chk("errcnt", 64'(hdr_err_cnt_o), 64'(m_err));
      chk("hdr",    64'(blk_header_o),  64'(m_hdr));
      chk("data",   blk_data_o,         m_data);
    end
  end

  function automatic logic [193:0] rnd_buf();
    logic [193:0] b;
    b = '0;
    for (int i = 0; i < 6; i++) b[i*32 +: 32] = $urandom();
    b[193:192] = 2'($urandom());
    return b;
  endfunction

  function automatic logic [5:0] rand_cnt(input int off);
    int hi;
    hi = 128 - off;
    if (hi > 63) hi = 63;
    if (hi < 0) hi = 0;
    return 6'($urandom_range(32'(hi), 0));
  endfunction

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(1, 0) == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic cyc(input logic dv, input logic [5:0] cnt, input logic [6:0] off,
                     input logic [193:0] b);
    gbox_buffer = b; gbox_cnt = cnt; block_offset = off; buffer_dv = dv;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // One dv cycle with header h placed wherever the aligner is currently looking.
  task automatic send(input logic [5:0] cnt, input int off, input logic [1:0] h);
    logic [193:0] b;
    int aoff, idx;
    b = rnd_buf();
    aoff = (m_state == 0) ? off : m_lock_off;
    idx = 193 - int'(cnt) - aoff;
    if (idx >= 65 && aoff <= 66) begin b[idx] = h[1]; b[idx-1] = h[0]; end
    cyc(1'b1, cnt, 7'(off), b);
  endtask

  task automatic idle();
    cyc(1'b0, 6'($urandom()), 7'($urandom()), rnd_buf());
  endtask

  task automatic do_reset();
    buffer_dv = 1'b0;
    rst_i = 1'b1;
    model_reset();
    @(posedge clk);
    model_step();
    #1 rst_i = 1'b0;
  endtask

  task automatic lock_at(input int off);
    for (int i = 0; i < 36; i++) send(rand_cnt(off), off, good_hdr());
  endtask

  logic [193:0] kb;
  int           off_r, err_base;

  initial begin
    rst_i = 1'b1; buffer_dv = 1'b0; gbox_buffer = '0; gbox_cnt = '0; block_offset = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_state", 64'(lock_state_o), 64'd0);
    chk("rst_valid", 64'(blk_valid_o), 64'd0);
    chk("rst_err", 64'(hdr_err_cnt_o), 64'd0);
    rst_i = 1'b0;

    // Stable offset 12: VERIFY after 4 dv, LOCKED after 32 more.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("hunt_before_4th", 64'(lock_state_o), 64'd0);
      send(rand_cnt(12), 12, good_hdr());
    end
    chk("verify_after_4", 64'(lock_state_o), 64'd1);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) chk("verify_before_32nd", 64'(lock_state_o), 64'd1);
      send(rand_cnt(12), 12, good_hdr());
    end
    chk("locked_after_32", 64'(locked_o), 64'd1);
    chk("no_strobe_at_lock", 64'(blk_valid_o), 64'd0);
    kb = '0;
    kb[179 -: 64] = 64'hDEADBEEF01234567;
    kb[181 -: 2]  = 2'b01;
    cyc(1'b1, 6'd0, 7'd12, kb);
    chk("first_valid", 64'(blk_valid_o), 64'd1);
    chk("first_hdr", 64'(blk_header_o), 64'h1);
    chk("first_data", blk_data_o, 64'hDEADBEEF01234567);
    idle();
    chk("strobe_one_clk", 64'(blk_valid_o), 64'd0);
    chk("data_hold", blk_data_o, 64'hDEADBEEF01234567);

    // Random locked traffic with gaps and sporadic bad headers.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(4, 0) == 0) idle();
      else if ($urandom_range(19, 0) == 0) send(rand_cnt(12), int'($urandom_range(127, 0)), ($urandom_range(1, 0) == 0) ? 2'b00 : 2'b11);
      else send(rand_cnt(12), int'($urandom_range(127, 0)), good_hdr());
    end

    // Bad-header threshold: 15 per window survives, 16 drops lock.
    do_reset();
    lock_at(12);
    chk("thr_locked", 64'(locked_o), 64'd1);
    for (int i = 0; i < 64; i++) send(rand_cnt(12), 12, (i < 15) ? 2'b11 : good_hdr());
    chk("thr_err15", 64'(hdr_err_cnt_o), 64'd15);
    chk("thr_still_locked", 64'(locked_o), 64'd1);
    for (int i = 0; i < 15; i++) send(rand_cnt(12), 12, 2'b11);
    chk("thr_window_cleared", 64'(locked_o), 64'd1);
    send(rand_cnt(12), 12, 2'b11);
    chk("thr_unlock", 64'(locked_o), 64'd0);
    chk("thr_hunt", 64'(lock_state_o), 64'd0);
    chk("thr_err31", 64'(hdr_err_cnt_o), 64'd31);

    // Offset jitter in HUNT: VERIFY only on the 6th dv, at offset 13.
    do_reset();
    send(rand_cnt(13), 12, good_hdr());
    send(rand_cnt(13), 12, good_hdr());
    for (int i = 0; i < 3; i++) send(rand_cnt(13), 13, good_hdr());
    chk("jitter_hunt", 64'(lock_state_o), 64'd0);
    send(rand_cnt(13), 13, good_hdr());
    chk("jitter_verify", 64'(lock_state_o), 64'd1);
    for (int i = 0; i < 32; i++) send(rand_cnt(13), int'($urandom_range(127, 0)), good_hdr());
    chk("jitter_locked", 64'(locked_o), 64'd1);
    kb = '0;
    kb[178 -: 64] = 64'h0F1E2D3C4B5A6978;
    kb[180 -: 2]  = 2'b10;
    cyc(1'b1, 6'd0, 7'd40, kb);
    chk("jitter_data", blk_data_o, 64'h0F1E2D3C4B5A6978);
    chk("jitter_hdr", 64'(blk_header_o), 64'h2);

    // Bad header in VERIFY at good_cnt=20.
    do_reset();
    for (int i = 0; i < 24; i++) send(rand_cnt(20), 20, good_hdr());
    chk("vbad_in_verify", 64'(lock_state_o), 64'd1);
    send(rand_cnt(20), 20, 2'b00);
    chk("vbad_hunt", 64'(lock_state_o), 64'd0);
    chk("vbad_no_strobe", 64'(blk_valid_o), 64'd0);

    // Range limit: offset 66 at gbox_cnt 63 lands header at bit 64.
    do_reset();
    lock_at(66);
    chk("range_locked", 64'(locked_o), 64'd1);
    err_base = int'(hdr_err_cnt_o);
    send(6'd63, 66, 2'b01);
    chk("range_no_block", 64'(blk_valid_o), 64'd0);
    chk("range_err", 64'(hdr_err_cnt_o), 64'(err_base + 1));
    send(6'd0, 66, 2'b10);
    chk("range_recover", 64'(blk_valid_o), 64'd1);

    // Async reset mid-dv while LOCKED.
    kb = rnd_buf();
    kb[127] = 1'b0; kb[126] = 1'b1;
    gbox_buffer = kb; gbox_cnt = 6'd0; block_offset = 7'd66; buffer_dv = 1'b1;
    #2 rst_i = 1'b1;
    model_reset();
    #1;
    chk("arst_valid", 64'(blk_valid_o), 64'd0);
    chk("arst_locked", 64'(locked_o), 64'd0);
    chk("arst_data", blk_data_o, 64'd0);
    chk("arst_err", 64'(hdr_err_cnt_o), 64'd0);
    @(posedge clk);
    model_step();
    #1 rst_i = 1'b0;
    for (int i = 0; i < 36; i++) begin
      send(rand_cnt(30), 30, good_hdr());
      if (i == 3) chk("arst_verify", 64'(lock_state_o), 64'd1);
    end
    chk("arst_relock", 64'(locked_o), 64'd1);
    send(rand_cnt(30), 30, good_hdr());
    chk("arst_strobe", 64'(blk_valid_o), 64'd1);

    // Random phase: jittering offsets, occasional out-of-range, mixed headers.
    do_reset();
    off_r = 40;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(6, 0) == 0) idle();
      else begin
        if ($urandom_range(9, 0) == 0) off_r = (off_r == 40) ? 41 : 40;
        if ($urandom_range(29, 0) == 0)
          send(6'($urandom()), int'($urandom_range(127, 60)), good_hdr());
        else if ($urandom_range(12, 0) == 0)
          send(rand_cnt(off_r), off_r, ($urandom_range(1, 0) == 0) ? 2'b00 : 2'b11);
        else
          send(rand_cnt(off_r), off_r, good_hdr());
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/block_aligner.md
Name: block_aligner

Overview:
- Consumes the gearbox buffer and the header offset from the header seeker.
- Runs a hunt/verify/lock state machine on the 2-bit sync header.
- Once locked, extracts aligned 66b blocks (2-bit header + 64-bit payload) for the downstream decoder.
- Sits directly downstream of the seeker, in parallel with it on the gearbox buffer.

Parameters:
- N_STABLE, 4: consecutive identical block_offset samples required to leave HUNT.
- N_LOCK, 32: consecutive valid headers in VERIFY required to declare lock.
- BAD_WIN, 64: block window length for bad-header accounting in LOCKED (power of 2).
- BAD_MAX, 16: bad headers within one window that force a return to HUNT.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- gbox_buffer  in  194  complete gearbox buffer.
- gbox_cnt  in  6  buffer view window index.
- buffer_dv  in  1  gbox_buffer/gbox_cnt valid this cycle.
- block_offset  in  7  header offset from the seeker.
- blk_header_o  out  2  sync header of the extracted block.
- blk_data_o  out  64  payload of the extracted block.
- blk_valid_o  out  1  one-cycle strobe, block outputs valid.
- locked_o  out  1  state == LOCKED.
- lock_state_o  out  2  0=HUNT, 1=VERIFY, 2=LOCKED.
- hdr_err_cnt_o  out  16  saturating count of bad headers seen while LOCKED.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (rst_i). All registers clear. state=HUNT; all outputs 0; stable counter and locked offset 0.
- Extraction on each buffer_dv cycle, with off = active offset (block_offset in HUNT, locked_off otherwise):
  - idx = 193 - gbox_cnt - off, computed at 8-bit unsigned width.
  - header = gbox_buffer[idx -: 2].
  - payload = gbox_buffer[idx-2 -: 64].
  - Out of range when idx < 65 or off > 66: the header counts as bad and no block is emitted.
- Header validity: good iff header is 2'b01 (data) or 2'b10 (cmd).
- HUNT:
  - On each dv, compare block_offset with the previous sample. Equal -> stable_cnt+1 (saturating); different -> stable_cnt=1.
  - When stable_cnt reaches N_STABLE, capture locked_off = block_offset, goto VERIFY, clear good_cnt.
- VERIFY:
  - dv with good header -> good_cnt+1.
  - good_cnt reaching N_LOCK -> LOCKED; clear the window and bad counters.
  - dv with bad header -> HUNT, stable_cnt=0.
- LOCKED:
  - Every dv with an in-range good header -> emit the block.
  - A bad header -> bad_cnt+1, hdr_err_cnt_o+1 (saturating at 16'hFFFF), no block emitted.
  - win_cnt increments per dv. When it wraps at BAD_WIN, clear bad_cnt.
  - bad_cnt reaching BAD_MAX -> HUNT; blk_valid_o is forced 0 from that cycle.
  - block_offset changes are ignored while in LOCKED.
- Latency: block outputs are registered and appear 1 clk after the buffer_dv cycle. blk_valid_o is high for exactly 1 clk.
- Holding: blk_header_o/blk_data_o hold their last value when blk_valid_o=0.
- No dv: all state and counters hold.
- Simultaneous events: when a bad header and a window wrap occur on the same dv, the increment applies first. The threshold check uses the incremented value, then bad_cnt clears.
- Reset mid-block: immediate return to HUNT. No partial strobe appears after rst_i deasserts.

Optional Feature:
- Macro BLOCK_ALIGNER_DESCRAMBLE_EN.
- Defined: emitted payload passes through a self-synchronising descrambler, polynomial 1+x^39+x^58, applied LSB-first.
  - 58-bit state updates only on emitted blocks; cleared on reset and on entry to LOCKED.
  - Header is not scrambled.
  - Latency unchanged (descramble is combinational before the output register).
- Undefined: payload is passed raw; no descrambler logic is present.

Decomposition:
- Package rx_align_pkg holds:
  - c_DATA_HEADER=2'b01, c_CMD_HEADER=2'b10.
  - Enum align_state_t {HUNT, VERIFY, LOCKED}.
  - Block struct {hdr[1:0], data[63:0]}.
- Sub-module rx_descrambler58 holds the descrambler (instantiated only under the macro). The FSM and extraction stay in block_aligner.

Test Plan:
- Stable offset: offset=12 constant, good headers every dv. Expect VERIFY after the 4th dv, LOCKED after 32 more dv, first blk_valid_o 1 clk after the next dv with the correct payload.
- Offset jitter in HUNT: offsets 12,12,13,13,13,13. Expect VERIFY entered only on the 6th dv with locked_off=13.
- Bad header in VERIFY: one header 2'b00 at good_cnt=20. Expect HUNT next cycle; no blk_valid_o ever asserted.
- Bad-header threshold in LOCKED:
  - 15 headers 2'b11 within a 64-block window: stays LOCKED, hdr_err_cnt_o=15, and bad_cnt clears at window end.
  - 16 bad headers in one window: HUNT; locked_o falls 1 clk after the 16th.
- Range limit: gbox_cnt=63, offset=66 (idx=64). Expect a bad header, no block emitted, and no out-of-bound slice.
- Async reset while LOCKED, mid-dv: all outputs 0 immediately. After release, a full HUNT/VERIFY sequence is required before the next strobe.
